// File: rtl/tdes_loader.sv
// tdes_loader: assembles key/data frames from a byte stream for a triple-DES core.
//
// Frame: header byte (bit1 = keys follow, bit0 = encrypt), optional 16 key
// bytes (key1 then key2, 8 bytes each), then 8 data bytes (MSB first).
//
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   in_byte/in_valid  serial byte input, transfers when in_valid && in_ready
//   in_ready          loader can accept a byte (low while a block is presented)
//   key1/key2         committed 56-bit parity-stripped keys
//   e                 direction for the presented block (1 = encrypt)
//   intext            assembled 64-bit block
//   blk_valid/ready   block handshake towards the core
//   keys_loaded       a key pair has been committed since reset
//   err/err_code      one-cycle error pulse; code 01 = key parity, 10 = no keys
module tdes_loader #(
    parameter bit CHECK_PARITY = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  in_byte,
    input  logic        in_valid,
    output logic        in_ready,
    output logic [55:0] key1,
    output logic [55:0] key2,
    output logic        e,
    output logic [63:0] intext,
    output logic        blk_valid,
    input  logic        blk_ready,
    output logic        keys_loaded,
    output logic        err,
    output logic [1:0]  err_code
);

    localparam int unsigned KEY_W = 56;
    localparam int unsigned SH_W  = 56;

    localparam logic [1:0] CODE_PARITY = 2'b01;
    localparam logic [1:0] CODE_NOKEY  = 2'b10;

    typedef enum logic [2:0] {
        S_IDLE,
        S_KEY,
        S_DATA,
        S_OUT,
        S_DROP
    } state_t;

    state_t           state;
    logic [3:0]       cnt;
    logic             frame_err;
    logic             hdr_e;
    logic [KEY_W-1:0] key_sh1;
    logic [KEY_W-1:0] key_sh2;
    logic [SH_W-1:0]  data_sh;

    logic xfer;
    logic par_bad;

    // A byte moves only on the handshake; odd parity is the valid DES key byte.
    assign xfer    = in_valid && in_ready;
    assign par_bad = CHECK_PARITY && !(^in_byte);

    // Frame sequencer with registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= S_IDLE;
            cnt         <= 4'd0;
            frame_err   <= 1'b0;
            hdr_e       <= 1'b0;
            key_sh1     <= '0;
            key_sh2     <= '0;
            data_sh     <= '0;
            in_ready    <= 1'b1;
            key1        <= '0;
            key2        <= '0;
            e           <= 1'b0;
            intext      <= '0;
            blk_valid   <= 1'b0;
            keys_loaded <= 1'b0;
            err         <= 1'b0;
            err_code    <= 2'b00;
        end else begin
            err <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (xfer) begin
                        hdr_e     <= in_byte[0];
                        cnt       <= 4'd0;
                        frame_err <= 1'b0;
                        if (in_byte[1]) begin
                            state <= S_KEY;
                        end else if (keys_loaded) begin
                            state <= S_DATA;
                        end else begin
                            state    <= S_DROP;
                            err      <= 1'b1;
                            err_code <= CODE_NOKEY;
                        end
                    end
                end

                S_KEY: begin
                    if (xfer) begin
                        // Parity bit 0 is dropped; first byte lands in the top 7 bits.
                        if (!cnt[3]) begin
                            key_sh1 <= {key_sh1[KEY_W-8:0], in_byte[7:1]};
                        end else begin
                            key_sh2 <= {key_sh2[KEY_W-8:0], in_byte[7:1]};
                        end
                        if (par_bad) begin
                            frame_err <= 1'b1;
                        end
                        if (cnt == 4'd15) begin
                            cnt <= 4'd0;
                            // Last byte's parity is folded in here, not via frame_err.
                            if (frame_err || par_bad) begin
                                state    <= S_DROP;
                                err      <= 1'b1;
                                err_code <= CODE_PARITY;
                            end else begin
                                key1        <= key_sh1;
                                key2        <= {key_sh2[KEY_W-8:0], in_byte[7:1]};
                                keys_loaded <= 1'b1;
                                state       <= S_DATA;
                            end
                        end else begin
                            cnt <= cnt + 4'd1;
                        end
                    end
                end

                S_DATA: begin
                    if (xfer) begin
                        data_sh <= {data_sh[SH_W-9:0], in_byte};
                        if (cnt == 4'd7) begin
                            cnt       <= 4'd0;
                            intext    <= {data_sh, in_byte};
                            e         <= hdr_e;
                            blk_valid <= 1'b1;
                            in_ready  <= 1'b0;
                            state     <= S_OUT;
                        end else begin
                            cnt <= cnt + 4'd1;
                        end
                    end
                end

                S_OUT: begin
                    if (blk_ready) begin
                        blk_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        state     <= S_IDLE;
                    end
                end

                S_DROP: begin
                    if (xfer) begin
                        if (cnt == 4'd7) begin
                            cnt   <= 4'd0;
                            state <= S_IDLE;
                        end else begin
                            cnt <= cnt + 4'd1;
                        end
                    end
                end

                default: begin
                    state    <= S_IDLE;
                    cnt      <= 4'd0;
                    in_ready <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_tdes_loader.sv
// Bench for tdes_loader: table of frames with fixed expected results, hand
// sequences for stall and mid-frame reset, random frames against a frame-level
// model, and a parity-disabled instance.
module tb_tdes_loader;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst0, rst1, sel;
    logic [7:0]  in_byte;
    logic        in_valid, blk_ready;

    logic        in_ready0, e0, blk_valid0, keys_loaded0, err0;
    logic [55:0] key1_0, key2_0;
    logic [63:0] intext0;
    logic [1:0]  err_code0;
    logic        in_ready1, e1, blk_valid1, keys_loaded1, err1;
    logic [55:0] key1_1, key2_1;
    logic [63:0] intext1;
    logic [1:0]  err_code1;

    tdes_loader #(.CHECK_PARITY(1'b1)) dut0 (
        .clk(clk), .rst(rst0), .in_byte(in_byte), .in_valid(in_valid),
        .in_ready(in_ready0), .key1(key1_0), .key2(key2_0), .e(e0),
        .intext(intext0), .blk_valid(blk_valid0), .blk_ready(blk_ready),
        .keys_loaded(keys_loaded0), .err(err0), .err_code(err_code0)
    );

    tdes_loader #(.CHECK_PARITY(1'b0)) dut1 (
        .clk(clk), .rst(rst1), .in_byte(in_byte), .in_valid(in_valid),
        .in_ready(in_ready1), .key1(key1_1), .key2(key2_1), .e(e1),
        .intext(intext1), .blk_valid(blk_valid1), .blk_ready(blk_ready),
        .keys_loaded(keys_loaded1), .err(err1), .err_code(err_code1)
    );

    // The unselected instance is held in reset; tasks look at the selected one.
    logic        c_in_ready, c_e, c_blk_valid, c_keys_loaded, c_err;
    logic [55:0] c_key1, c_key2;
    logic [63:0] c_intext;
    logic [1:0]  c_err_code;
    assign c_in_ready    = sel ? in_ready1    : in_ready0;
    assign c_e           = sel ? e1           : e0;
    assign c_blk_valid   = sel ? blk_valid1   : blk_valid0;
    assign c_keys_loaded = sel ? keys_loaded1 : keys_loaded0;
    assign c_err         = sel ? err1         : err0;
    assign c_key1        = sel ? key1_1       : key1_0;
    assign c_key2        = sel ? key2_1       : key2_0;
    assign c_intext      = sel ? intext1      : intext0;
    assign c_err_code    = sel ? err_code1    : err_code0;

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", name, act, exp);
        end
    endtask

    // Event monitors, sampled on the falling edge.
    int   err_pulses = 0;
    int   blk_rises  = 0;
    logic blk_prev   = 1'b0;
    always @(negedge clk) begin
        if (c_err === 1'b1) err_pulses++;
        if (c_blk_valid === 1'b1 && blk_prev !== 1'b1) blk_rises++;
        blk_prev = c_blk_valid;
    end

    task automatic send_byte(input logic [7:0] b, input int gap);
        int n;
        repeat (gap) @(negedge clk);
        @(negedge clk);
        in_byte  = b;
        in_valid = 1'b1;
        n = 0;
        while (c_in_ready !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (c_in_ready !== 1'b1) begin
            checks++;
            errors++;
            $display("FAIL in_ready_timeout got=%b exp=1", c_in_ready);
            in_valid = 1'b0;
            return;
        end
        @(posedge clk);
        #1 in_valid = 1'b0;
    endtask

    task automatic send_frame(input logic [7:0] hdr, input logic [127:0] kb,
                              input logic [63:0] db, input int maxgap);
        send_byte(hdr, maxgap > 0 ? int'($urandom_range(maxgap, 0)) : 0);
        if (hdr[1]) begin
            for (int i = 0; i < 16; i++)
                send_byte(kb[127-8*i -: 8], maxgap > 0 ? int'($urandom_range(maxgap, 0)) : 0);
        end
        for (int i = 0; i < 8; i++)
            send_byte(db[63-8*i -: 8], maxgap > 0 ? int'($urandom_range(maxgap, 0)) : 0);
    endtask

    // Wait briefly for a block; if one shows up, capture it and accept it after 'hold' cycles.
    task automatic take_block(input int hold, output logic got,
                              output logic [63:0] t, output logic ee);
        got = 1'b0;
        t   = '0;
        ee  = 1'b0;
        for (int i = 0; i < 4 && !got; i++) begin
            @(negedge clk);
            if (c_blk_valid === 1'b1) got = 1'b1;
        end
        if (got) begin
            t  = c_intext;
            ee = c_e;
            repeat (hold) @(negedge clk);
            blk_ready = 1'b1;
            @(posedge clk);
            #1 blk_ready = 1'b0;
        end
        @(negedge clk);
    endtask

    typedef struct {
        logic [7:0]   hdr;
        logic [127:0] keys;
        logic [63:0]  data;
        logic         exp_err;
        logic [1:0]   exp_code;
        logic         exp_blk;
        logic [55:0]  exp_k1;
        logic [55:0]  exp_k2;
        logic         exp_loaded;
        logic [63:0]  exp_text;
        logic         exp_e;
    } vec_t;

    localparam logic [127:0] K_STD  = 128'h133457799BBCDFF1_133457799BBCDFF1;
    localparam logic [127:0] K_BAD  = 128'h123457799BBCDFF1_133457799BBCDFF1;
    localparam logic [127:0] K_BADL = 128'h133457799BBCDFF1_133457799BBCDFF0;
    localparam logic [127:0] K_NEW  = 128'h0102040810204080_FEFEFEFEFEFEFEFE;
    localparam logic [55:0]  KS_STD = 56'h12695BC9B7B7F8;
    localparam logic [55:0]  KS_N1  = 56'h00041041041040;
    localparam logic [55:0]  KS_N2  = 56'hFFFFFFFFFFFFFF;

    // Frame-level reference: stripped key is the seven high bits of each byte, byte 0 first.
    function automatic logic [55:0] strip(input logic [63:0] kb8);
        logic [55:0] k = '0;
        for (int i = 0; i < 8; i++) begin
            logic [7:0] b = kb8[63-8*i -: 8];
            k = k | (56'(b >> 1) << (7 * (7 - i)));
        end
        return k;
    endfunction

    function automatic logic parity_ok(input logic [127:0] kb);
        for (int i = 0; i < 16; i++) begin
            logic [7:0] b = kb[127-8*i -: 8];
            if ($countones(b) % 2 == 0) return 1'b0;
        end
        return 1'b1;
    endfunction

    task automatic compare_frame(input string tag, input int de, input int db, input logic got,
                                 input logic [63:0] t, input logic ee,
                                 input logic x_err, input logic [1:0] x_code, input logic x_blk,
                                 input logic [55:0] x_k1, input logic [55:0] x_k2,
                                 input logic x_loaded, input logic [63:0] x_text, input logic x_e);
        check({tag, "_errpulse"}, 64'(de), 64'(x_err));
        check({tag, "_blkrise"},  64'(db), 64'(x_blk));
        check({tag, "_blkseen"},  64'(got), 64'(x_blk));
        check({tag, "_errcode"},  64'(c_err_code), 64'(x_code));
        check({tag, "_key1"},     64'(c_key1), 64'(x_k1));
        check({tag, "_key2"},     64'(c_key2), 64'(x_k2));
        check({tag, "_loaded"},   64'(c_keys_loaded), 64'(x_loaded));
        if (x_blk && got) begin
            check({tag, "_intext"}, t, x_text);
            check({tag, "_e"},      64'(ee), 64'(x_e));
        end
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, "_key1"},    64'(c_key1), 64'h0);
        check({tag, "_key2"},    64'(c_key2), 64'h0);
        check({tag, "_intext"},  c_intext, 64'h0);
        check({tag, "_e"},       64'(c_e), 64'h0);
        check({tag, "_blkv"},    64'(c_blk_valid), 64'h0);
        check({tag, "_loaded"},  64'(c_keys_loaded), 64'h0);
        check({tag, "_err"},     64'(c_err), 64'h0);
        check({tag, "_errcode"}, 64'(c_err_code), 64'h0);
        check({tag, "_inready"}, 64'(c_in_ready), 64'h1);
    endtask

    task automatic pulse_reset0();
        @(negedge clk);
        rst0 = 1'b1;
        @(negedge clk);
        rst0 = 1'b0;
        @(negedge clk);
    endtask

    vec_t vecs[8];

    initial begin
        int          e_before, b_before;
        logic        got, ee;
        logic [63:0] t, snap_t;
        logic        snap_e;

        vecs[0] = '{8'h00, 128'h0,  64'h0102030405060708, 1'b1, 2'b10, 1'b0, 56'h0,  56'h0,  1'b0, 64'h0, 1'b0};
        vecs[1] = '{8'h03, K_STD,   64'h0102030405060708, 1'b0, 2'b10, 1'b1, KS_STD, KS_STD, 1'b1, 64'h0102030405060708, 1'b1};
        vecs[2] = '{8'h00, 128'h0,  64'h1112131415161718, 1'b0, 2'b10, 1'b1, KS_STD, KS_STD, 1'b1, 64'h1112131415161718, 1'b0};
        vecs[3] = '{8'h02, K_BAD,   64'hA5A5A5A5A5A5A5A5, 1'b1, 2'b01, 1'b0, KS_STD, KS_STD, 1'b1, 64'h0, 1'b0};
        vecs[4] = '{8'h01, 128'h0,  64'hA0A1A2A3A4A5A6A7, 1'b0, 2'b01, 1'b1, KS_STD, KS_STD, 1'b1, 64'hA0A1A2A3A4A5A6A7, 1'b1};
        vecs[5] = '{8'hFE, K_NEW,   64'hDEADBEEFCAFEF00D, 1'b0, 2'b01, 1'b1, KS_N1,  KS_N2,  1'b1, 64'hDEADBEEFCAFEF00D, 1'b0};
        vecs[6] = '{8'hFD, 128'h0,  64'h0011223344556677, 1'b0, 2'b01, 1'b1, KS_N1,  KS_N2,  1'b1, 64'h0011223344556677, 1'b1};
        vecs[7] = '{8'h03, K_BADL,  64'h5A5A5A5A5A5A5A5A, 1'b1, 2'b01, 1'b0, KS_N1,  KS_N2,  1'b1, 64'h0, 1'b0};

        rst0 = 1'b1; rst1 = 1'b1; sel = 1'b0;
        in_byte = 8'h00; in_valid = 1'b0; blk_ready = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst0 = 1'b0;
        @(negedge clk);
        check_reset_state("reset");

        // Table-driven frames.
        for (int i = 0; i < 8; i++) begin
            e_before = err_pulses;
            b_before = blk_rises;
            send_frame(vecs[i].hdr, vecs[i].keys, vecs[i].data, i % 3);
            take_block(i % 2, got, t, ee);
            compare_frame($sformatf("vec%0d", i), err_pulses - e_before, blk_rises - b_before,
                          got, t, ee, vecs[i].exp_err, vecs[i].exp_code, vecs[i].exp_blk,
                          vecs[i].exp_k1, vecs[i].exp_k2, vecs[i].exp_loaded,
                          vecs[i].exp_text, vecs[i].exp_e);
        end

        // Core stalls for 5 cycles while bytes are offered.
        b_before = blk_rises;
        send_frame(8'h00, 128'h0, 64'h8081828384858687, 0);
        got = 1'b0;
        for (int i = 0; i < 4 && !got; i++) begin
            @(negedge clk);
            if (c_blk_valid === 1'b1) got = 1'b1;
        end
        check("stall_blkv_rise", 64'(got), 64'h1);
        snap_t = c_intext;
        snap_e = c_e;
        check("stall_snap_text", snap_t, 64'h8081828384858687);
        check("stall_snap_e", 64'(snap_e), 64'h0);
        in_byte  = 8'hFF;
        in_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check($sformatf("stall%0d_blkv", i),  64'(c_blk_valid), 64'h1);
            check($sformatf("stall%0d_text", i),  c_intext, snap_t);
            check($sformatf("stall%0d_e", i),     64'(c_e), 64'(snap_e));
            check($sformatf("stall%0d_inrdy", i), 64'(c_in_ready), 64'h0);
        end
        blk_ready = 1'b1;
        @(posedge clk);
        #1;
        blk_ready = 1'b0;
        in_valid  = 1'b0;
        @(negedge clk);
        check("stall_blkv_drop", 64'(c_blk_valid), 64'h0);
        check("stall_inrdy_back", 64'(c_in_ready), 64'h1);
        check("stall_one_xfer", 64'(blk_rises - b_before), 64'h1);
        // The bytes offered during the stall must not have been taken as a header.
        send_frame(8'h01, 128'h0, 64'h9192939495969798, 0);
        take_block(0, got, t, ee);
        check("after_stall_blk", 64'(got), 64'h1);
        check("after_stall_text", t, 64'h9192939495969798);
        check("after_stall_e", 64'(ee), 64'h1);

        // Reset after the 4th data byte.
        send_byte(8'h01, 0);
        for (int i = 0; i < 4; i++) send_byte(8'h10 + 8'(i), 0);
        pulse_reset0();
        check_reset_state("midrst");
        e_before = err_pulses;
        b_before = blk_rises;
        send_frame(8'h00, 128'h0, 64'h2122232425262728, 0);
        take_block(0, got, t, ee);
        compare_frame("midrst_nokey", err_pulses - e_before, blk_rises - b_before, got, t, ee,
                      1'b1, 2'b10, 1'b0, 56'h0, 56'h0, 1'b0, 64'h0, 1'b0);

        // Random frames against the frame-level model.
        pulse_reset0();
        begin
            logic [55:0]  mk1 = '0, mk2 = '0;
            logic         mloaded = 1'b0;
            logic [1:0]   mcode = 2'b00;
            logic [7:0]   hdr, b;
            logic [127:0] kb;
            logic [63:0]  db;
            logic         x_err, x_blk;
            for (int f = 0; f < 40; f++) begin
                hdr = 8'($urandom);
                if (f < 2) hdr[1] = 1'b0;
                kb = '0;
                for (int i = 0; i < 16; i++) begin
                    b = 8'($urandom);
                    b[0] = ~(^b[7:1]);
                    if ($urandom_range(9, 0) == 0) b[0] = ~b[0];
                    kb[127-8*i -: 8] = b;
                end
                db = {32'($urandom), 32'($urandom)};
                x_err = 1'b0;
                x_blk = 1'b0;
                if (hdr[1]) begin
                    if (parity_ok(kb)) begin
                        mk1 = strip(kb[127:64]);
                        mk2 = strip(kb[63:0]);
                        mloaded = 1'b1;
                        x_blk = 1'b1;
                    end else begin
                        x_err = 1'b1;
                        mcode = 2'b01;
                    end
                end else if (mloaded) begin
                    x_blk = 1'b1;
                end else begin
                    x_err = 1'b1;
                    mcode = 2'b10;
                end
                e_before = err_pulses;
                b_before = blk_rises;
                send_frame(hdr, kb, db, 2);
                take_block(int'($urandom_range(3, 0)), got, t, ee);
                compare_frame($sformatf("rnd%0d", f), err_pulses - e_before, blk_rises - b_before,
                              got, t, ee, x_err, mcode, x_blk, mk1, mk2, mloaded, db, hdr[0]);
            end
        end

        // Parity checking disabled: an even-parity key byte is accepted.
        @(negedge clk);
        rst0 = 1'b1;
        sel  = 1'b1;
        @(negedge clk);
        rst1 = 1'b0;
        @(negedge clk);
        check_reset_state("np_reset");
        e_before = err_pulses;
        b_before = blk_rises;
        send_frame(8'h03, K_BAD, 64'h3132333435363738, 1);
        take_block(1, got, t, ee);
        compare_frame("noparity", err_pulses - e_before, blk_rises - b_before, got, t, ee,
                      1'b0, 2'b00, 1'b1, KS_STD, KS_STD, 1'b1, 64'h3132333435363738, 1'b1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    // Global watchdog.
    initial begin
        #2000000;
        $display("FAIL watchdog got=timeout exp=finish");
        $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
        $fatal(1);
    end

endmodule

// File: doc/tdes_loader.md
TDES_LOADER -- requirements
Module: tdes_loader

Interface
REQ-001 Parameter CHECK_PARITY, default 1: 1 = enforce DES odd parity on key bytes; 0 = ignore parity bits.
REQ-002 clk  in  1  sole clock; all state updates on its rising edge.
REQ-003 rst  in  1  reset, synchronous and active-high.
REQ-004 in_byte  in  8  serial frame byte.
REQ-005 in_valid  in  1  in_byte valid; a byte transfers on a cycle with in_valid && in_ready.
REQ-006 in_ready  out  1  loader can accept a byte.
REQ-007 key1  out  56  committed stripped key 1, to the triple-DES core.
REQ-008 key2  out  56  committed stripped key 2, to the triple-DES core.
REQ-009 e  out  1  direction for the presented block: 1 = encrypt, 0 = decrypt.
REQ-010 intext  out  64  assembled 64-bit block.
REQ-011 blk_valid  out  1  e/key1/key2/intext valid for the core.
REQ-012 blk_ready  in  1  core accepts the block; the block transfers on blk_valid && blk_ready.
REQ-013 keys_loaded  out  1  at least one key pair committed since reset.
REQ-014 err  out  1  one-cycle error pulse.
REQ-015 err_code  out  2  01 = key parity error, 10 = no keys loaded; holds until the next err.

Function
REQ-016 Frame format: header byte; then 16 key bytes if header[1] = 1 (key1 bytes 0-7, then key2 bytes 0-7); then 8 data bytes; header[0] = e; header[7:2] are ignored.
REQ-017 FSM states: IDLE (await header), KEY (byte count 0-15), DATA (byte count 0-7), OUT (present block), DROP (discard the remaining data bytes of a bad frame).
REQ-018 in_ready = 1 in IDLE/KEY/DATA/DROP and 0 in OUT.
REQ-019 IDLE transitions on header transfer: header[1] = 1 -> KEY; header[1] = 0 with keys_loaded = 1 -> DATA; header[1] = 0 with keys_loaded = 0 -> DROP, plus err pulse with err_code = 10.
REQ-020 Key stripping: each key byte contributes bits [7:1] (bit 0 is parity); the first byte supplies key bits [55:49], the eighth byte bits [6:0].
REQ-021 Key bytes accumulate in shadow registers; key1/key2 are not altered until commit.
REQ-022 With CHECK_PARITY = 1, a key byte with an even count of ones sets a frame-error flag.
REQ-023 After the 16th key byte: no error -> key1/key2 commit together on the next edge, keys_loaded = 1, go to DATA; error -> no commit, err pulse with err_code = 01, go to DROP.
REQ-024 DROP consumes exactly 8 bytes and then returns to IDLE with no blk_valid.
REQ-025 Data bytes load MSB-first: data byte 0 -> intext[63:56], data byte 7 -> intext[7:0].
REQ-026 blk_valid rises on the cycle after the 8th data byte transfers; e is latched from the header.
REQ-027 In OUT, blk_valid and all block outputs stay stable until blk_ready; on the transfer edge blk_valid drops and the FSM returns to IDLE.
REQ-028 Back-to-back operation: in_ready returns one cycle after the block transfer; bytes offered while in_ready = 0 are not consumed.
REQ-029 Byte counters wrap to 0 on every state exit.
REQ-030 in_valid = 0 stalls the FSM with no state change.

Reset
REQ-031 While rst = 1 at an edge: state = IDLE, counters = 0, the frame-error flag is cleared, and all outputs are 0 (key1, key2, intext, e, blk_valid, keys_loaded, err, err_code), except in_ready = 1 after the reset edge.
REQ-032 Reset mid-frame or in OUT discards the partial frame or pending block; the next byte after reset is treated as a header.

Verification
REQ-033 Header 0x03, key1 bytes 13 34 57 79 9B BC DF F1, key2 same, data 01..08 -> key1 = key2 = 0x12695BC9B7B7F8, intext = 0x0102030405060708, e = 1, blk_valid on the cycle after the last byte, keys_loaded = 1.
REQ-034 After the above, header 0x00 plus 8 data bytes -> no key change, e = 0, block presented.
REQ-035 Key frame with first key byte 0x12 (even parity) -> err pulse, err_code = 01, prior keys retained, 8 data bytes dropped, no blk_valid; with CHECK_PARITY = 0 the same frame is accepted.
REQ-036 Header 0x00 straight after reset -> err pulse, err_code = 10, 8 bytes dropped, no blk_valid.
REQ-037 blk_ready held low for 5 cycles -> blk_valid and outputs stable, in_ready = 0, offered bytes not consumed; then blk_ready = 1 -> one transfer, then IDLE.
REQ-038 rst asserted after the 4th data byte -> all outputs 0, keys_loaded = 0; a following header 0x00 produces err_code = 10.
